// File: rtl/cache_fill_controller.sv
// Cache block fill controller: on a miss it issues eight word reads for the
// missing block and writes returned words into the data array, then the tag.
module cache_fill_controller #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [2:0]            word_index,
  output logic                  write_tag_array,
  output logic                  fill_done
);

  localparam int         BLK_W     = ADDR_WIDTH - 4;
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic [2:0]       req_cnt_q, req_cnt_d;
  logic [2:0]       rx_cnt_q, rx_cnt_d;
  logic             req_done_q, req_done_d;

  // Byte offset within the block is implied by the word counters.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      block_q    <= '0;
      req_cnt_q  <= '0;
      rx_cnt_q   <= '0;
      req_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      req_cnt_q  <= req_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      req_done_q <= req_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    block_d          = block_q;
    req_cnt_d        = req_cnt_q;
    rx_cnt_d         = rx_cnt_q;
    req_done_d       = req_done_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          block_d    = miss_address[ADDR_WIDTH-1:4];
          req_cnt_d  = '0;
          rx_cnt_d   = '0;
          req_done_d = 1'b0;
          state_d    = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        // Request and receive sides advance independently; only valids
        // decide completion, so any memory latency is tolerated.
        if (!req_done_q) begin
          mem_read_en    = 1'b1;
          memory_address = {block_q, req_cnt_q, 1'b0};
          req_cnt_d      = req_cnt_q + 3'd1;
          if (req_cnt_q == LAST_WORD) req_done_d = 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = rx_cnt_q;
          rx_cnt_d         = rx_cnt_q + 3'd1;
          if (rx_cnt_q == LAST_WORD) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench for cache_fill_controller using a transaction-level
// model (issued/received word counts per fill) and a simple memory responder.
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address;
  logic [2:0]  word_index;

  cache_fill_controller #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy), .mem_read_en(mem_read_en),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .word_index(word_index), .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = -1;

  // Reference model: a fill is a block base plus counts of words issued/received.
  bit          m_busy = 1'b0;
  int unsigned m_base = 0;
  int unsigned m_nreq = 0;
  int unsigned m_nrx  = 0;

  // Memory responder: mode 0 = fixed 4-cycle latency, mode 1 = random gaps.
  int          mem_mode = 0;
  logic [3:0]  rd_hist = '0;
  int unsigned gap = 0;
  bit          spurious_ok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic m, input logic [15:0] a, input logic force_v);
    logic        v, e_rd, e_wr, e_done;
    logic [15:0] e_addr;
    logic [2:0]  e_idx;
    @(negedge clk);
    e_rd = m_busy && (m_nreq < 8);
    if (mem_mode == 0) v = rd_hist[3];
    else if (m_busy) v = (gap == 0) && (m_nrx < m_nreq + (e_rd ? 1 : 0));
    else v = spurious_ok && ($urandom_range(0, 3) == 0);
    v = v | force_v;
    rst = r; miss_detected = m; miss_address = a; memory_data_valid = v;
    #2;
    e_addr = e_rd ? 16'(m_base + 2 * m_nreq) : 16'h0000;
    e_wr   = m_busy && v;
    e_idx  = e_wr ? 3'(m_nrx) : 3'd0;
    e_done = e_wr && (m_nrx == 7);
    chk("fsm_busy", {31'b0, fsm_busy}, {31'b0, m_busy});
    chk("mem_read_en", {31'b0, mem_read_en}, {31'b0, e_rd});
    chk("memory_address", {16'b0, memory_address}, {16'b0, e_addr});
    chk("write_data_array", {31'b0, write_data_array}, {31'b0, e_wr});
    chk("word_index", {29'b0, word_index}, {29'b0, e_idx});
    chk("write_tag_array", {31'b0, write_tag_array}, {31'b0, e_done});
    chk("fill_done", {31'b0, fill_done}, {31'b0, e_done});
    if (fill_done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (mem_mode == 1 && m_busy) begin
      if (v) gap = $urandom_range(0, 3);
      else if (gap > 0) gap--;
    end
    if (r) begin
      m_busy = 0; m_base = 0; m_nreq = 0; m_nrx = 0;
      rd_hist = '0;
    end else begin
      if (!m_busy) begin
        if (m) begin
          m_busy = 1; m_base = a & 16'hFFF0; m_nreq = 0; m_nrx = 0;
        end
      end else begin
        if (e_rd) m_nreq++;
        if (e_wr) m_nrx++;
        if (e_done) m_busy = 0;
      end
      rd_hist = {rd_hist[2:0], e_rd};
    end
    cyc++;
  endtask

  task automatic run_fill(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      n++;
    end
    chk("fill_timeout", {31'b0, m_busy}, 32'd0);
  endtask

  initial begin
    int t_miss;
    int d0;
    int n;
    logic r, m;
    // Establish a known state before any checked cycle.
    rst = 1'b1;
    @(posedge clk);
    cyc = 1;

    // Reset held with a pending miss: nothing starts.
    cycle(1'b1, 1'b1, 16'h1236, 1'b0);
    cycle(1'b1, 1'b1, 16'h1236, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Basic fill with a 4-cycle memory.
    mem_mode = 0;
    t_miss = cyc;
    cycle(1'b0, 1'b1, 16'h1236, 1'b0);
    run_fill(30);
    chk("basic_done_latency", 32'(last_done_cyc - t_miss), 32'd12);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);

    // Irregular returns with 0-3 idle cycles between valids.
    mem_mode = 1; spurious_ok = 1'b0; gap = 2;
    d0 = done_count;
    cycle(1'b0, 1'b1, 16'h4A2C, 1'b0);
    run_fill(60);
    chk("irregular_done_count", 32'(done_count - d0), 32'd1);

    // Reset after three reads, then a fresh fill.
    mem_mode = 0;
    cycle(1'b0, 1'b1, 16'h5550, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    t_miss = cyc;
    cycle(1'b0, 1'b1, 16'hABC0, 1'b0);
    run_fill(30);
    chk("restart_done_latency", 32'(last_done_cyc - t_miss), 32'd12);

    // Miss held across two fills; spurious valid on the idle cycle between.
    d0 = done_count;
    cycle(1'b0, 1'b1, 16'h2220, 1'b0);
    n = 0;
    while (done_count == d0 && n < 40) begin
      cycle(1'b0, 1'b1, 16'h2220, 1'b0);
      n++;
    end
    cycle(1'b0, 1'b1, 16'h3334, 1'b1);
    run_fill(30);
    chk("back_to_back_done_count", 32'(done_count - d0), 32'd2);

    // Top block must not wrap to address 0.
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_fill(30);

    // Random traffic: misses, gapped returns, stray valids and rare resets.
    mem_mode = 1; spurious_ok = 1'b1; gap = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      m = ($urandom_range(0, 2) == 0);
      cycle(r, m, 16'($urandom), 1'b0);
    end
    spurious_ok = 1'b0;
    run_fill(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
